regfile_scb: RTL and testbench

REGFILE_SCB -- requirements
Module: regfile_scb

---
 rtl/regfile_pkg.sv | 10 +
 rtl/regfile_scoreboard.sv | 95 +++++++++
 rtl/regfile_scb.sv | 104 ++++++++++
 tb/tb_regfile_scb.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    // Hard-wired zero register; reads as 0, ignores writes, never busy.
    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an outstanding load, accepts
// reserves, and flags writeback hazards with a sticky error.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic              rsv,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rbusy1,
    output logic              rbusy2,
    output logic              rsv_ok,
    output logic              err
);

    localparam int unsigned       DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic             err_nxt;
    logic             wr0_en;
    logic             wr1_en;
    logic             set_en;
    logic             waw_hit;
    logic             stray_hit;

    assign wr0_en = we0 && (waddr0 != ZERO_A);
    assign wr1_en = we1 && (waddr1 != ZERO_A);

    // Reserve is accepted unless the target is busy and not being released now.
    always_comb begin
        rsv_ok = 1'b0;
        if (rsv) begin
            rsv_ok = (rsv_addr == ZERO_A) || !busy[rsv_addr] ||
                     (wr1_en && (waddr1 == rsv_addr));
        end
    end

    assign set_en = rsv_ok && (rsv_addr != ZERO_A);

    // Load writeback clears first so a same-cycle reserve leaves the bit set.
    always_comb begin
        busy_nxt = busy;
        if (wr1_en) begin
            busy_nxt[waddr1] = 1'b0;
        end
        if (set_en) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // WAW: ALU write into a pending load target; stray: load write with no reservation.
    always_comb begin
        waw_hit   = wr0_en && busy[waddr0];
        stray_hit = wr1_en && !busy[waddr1];
        err_nxt   = err || waw_hit || stray_hit;
    end

    // Busy read-out, hidden when the releasing write is forwarded this cycle.
    always_comb begin
        rbusy1 = busy[raddr1];
        rbusy2 = busy[raddr2];
        if (BYPASS != 0) begin
            if (wr1_en && (waddr1 == raddr1)) begin
                rbusy1 = 1'b0;
            end
            if (wr1_en && (waddr1 == raddr2)) begin
                rbusy2 = 1'b0;
            end
        end
    end

    // Scoreboard state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
            err  <= 1'b0;
        end else begin
            busy <= busy_nxt;
            err  <= err_nxt;
        end
    end

endmodule

// File: rtl/regfile_scb.sv
// Two-read, two-write register file with load-busy scoreboard and optional
// same-cycle write-to-read forwarding.
module regfile_scb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] i_raddr1,
    input  logic [ADDR_W-1:0] i_raddr2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2,
    output logic              o_rbusy1,
    output logic              o_rbusy2,
    input  logic              i_we0,
    input  logic [ADDR_W-1:0] i_waddr0,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_waddr1,
    input  logic [DATA_W-1:0] i_wdata1,
    input  logic              i_rsv,
    input  logic [ADDR_W-1:0] i_rsv_addr,
    output logic              o_rsv_ok,
    output logic              o_err
);

    localparam int unsigned       DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr0_en;
    logic              wr1_en;

    assign wr0_en = i_we0 && (i_waddr0 != ZERO_A);
    assign wr1_en = i_we1 && (i_waddr1 != ZERO_A);

    // Storage; port 1 is written last so it wins an address collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs <= '{default: '0};
        end else begin
            if (wr0_en) begin
                regs[i_waddr0] <= i_wdata0;
            end
            if (wr1_en) begin
                regs[i_waddr1] <= i_wdata1;
            end
        end
    end

    // Read port 1 with optional forwarding (port 1 over port 0).
    always_comb begin
        o_rdata1 = regs[i_raddr1];
        if (BYPASS != 0) begin
            if (wr1_en && (i_waddr1 == i_raddr1)) begin
                o_rdata1 = i_wdata1;
            end else if (wr0_en && (i_waddr0 == i_raddr1)) begin
                o_rdata1 = i_wdata0;
            end
        end
        if (!reset_n || (i_raddr1 == ZERO_A)) begin
            o_rdata1 = '0;
        end
    end

    // Read port 2 with optional forwarding (port 1 over port 0).
    always_comb begin
        o_rdata2 = regs[i_raddr2];
        if (BYPASS != 0) begin
            if (wr1_en && (i_waddr1 == i_raddr2)) begin
                o_rdata2 = i_wdata1;
            end else if (wr0_en && (i_waddr0 == i_raddr2)) begin
                o_rdata2 = i_wdata0;
            end
        end
        if (!reset_n || (i_raddr2 == ZERO_A)) begin
            o_rdata2 = '0;
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .reset_n  (reset_n),
        .raddr1   (i_raddr1),
        .raddr2   (i_raddr2),
        .we0      (i_we0),
        .waddr0   (i_waddr0),
        .we1      (i_we1),
        .waddr1   (i_waddr1),
        .rsv      (i_rsv),
        .rsv_addr (i_rsv_addr),
        .rbusy1   (o_rbusy1),
        .rbusy2   (o_rbusy2),
        .rsv_ok   (o_rsv_ok),
        .err      (o_err)
    );

endmodule

// File: tb/tb_regfile_scb.sv
// Directed bench for regfile_scb: a forwarding instance and a non-forwarding
// instance share one stimulus stream.
module tb_regfile_scb;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] raddr1, raddr2, waddr0, waddr1, rsv_addr;
    logic [DW-1:0] wdata0, wdata1;
    logic          we0, we1, rsv;

    logic [DW-1:0] rdata1, rdata2, nb_rdata1, nb_rdata2;
    logic          rbusy1, rbusy2, rsv_ok, err;
    logic          nb_rbusy1, nb_rbusy2, nb_rsv_ok, nb_err;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t rd_q[$];

    always #5 clk = ~clk;

    regfile_scb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_raddr1(raddr1), .i_raddr2(raddr2),
        .o_rdata1(rdata1), .o_rdata2(rdata2),
        .o_rbusy1(rbusy1), .o_rbusy2(rbusy2),
        .i_we0(we0), .i_waddr0(waddr0), .i_wdata0(wdata0),
        .i_we1(we1), .i_waddr1(waddr1), .i_wdata1(wdata1),
        .i_rsv(rsv), .i_rsv_addr(rsv_addr),
        .o_rsv_ok(rsv_ok), .o_err(err)
    );

    regfile_scb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0)) dut_nb (
        .clk(clk), .reset_n(reset_n),
        .i_raddr1(raddr1), .i_raddr2(raddr2),
        .o_rdata1(nb_rdata1), .o_rdata2(nb_rdata2),
        .o_rbusy1(nb_rbusy1), .o_rbusy2(nb_rbusy2),
        .i_we0(we0), .i_waddr0(waddr0), .i_wdata0(wdata0),
        .i_we1(we1), .i_waddr1(waddr1), .i_wdata1(wdata1),
        .i_rsv(rsv), .i_rsv_addr(rsv_addr),
        .o_rsv_ok(nb_rsv_ok), .o_err(nb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_rd(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        rd_q.push_back(e);
    endtask

    // Compare the forwarding instance's read port 1 against the oldest expectation.
    task automatic pop_rd1();
        exp_t e;
        if (rd_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL rd_queue observed=empty expected=entry");
        end else begin
            e = rd_q.pop_front();
            chk(e.tag, rdata1, e.exp);
        end
    endtask

    task automatic idle();
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        rsv = 1'b0; rsv_addr = '0;
    endtask

    // Start a cycle just after the rising edge with writes/reserves deasserted.
    task automatic begin_cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        begin_cyc();
        reset_n = 1'b0;
        sample();
        #1 reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        raddr1 = '0;
        raddr2 = '0;
        idle();

        // Reset state; write and reserve presented during reset are dropped.
        begin_cyc();
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h0000_0099;
        rsv = 1'b1; rsv_addr = 5'd5; raddr1 = 5'd5;
        sample();
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_rbusy1", 32'(rbusy1), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_rsv_ok", 32'(rsv_ok), 32'h1);
        idle();
        #1 reset_n = 1'b1;
        begin_cyc();
        raddr1 = 5'd5;
        push_rd("rst_write_dropped", 32'h0);
        sample();
        pop_rd1();
        chk("rst_busy_dropped", 32'(rbusy1), 32'h0);

        // Port 0 write, visible next cycle.
        begin_cyc();
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEAD_BEEF;
        begin_cyc();
        raddr1 = 5'd5;
        push_rd("r5_readback", 32'hDEAD_BEEF);
        sample();
        pop_rd1();
        chk("r5_readback_nb", nb_rdata1, 32'hDEAD_BEEF);

        // Register 0 ignores writes, including the forwarding path.
        begin_cyc();
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h0000_1234; raddr1 = 5'd0;
        push_rd("r0_bypass", 32'h0);
        sample();
        pop_rd1();
        begin_cyc();
        raddr1 = 5'd0;
        push_rd("r0_stored", 32'h0);
        sample();
        pop_rd1();

        // Same-cycle forwarding vs stored value.
        begin_cyc();
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'hA5A5_A5A5; raddr1 = 5'd7;
        push_rd("r7_bypass", 32'hA5A5_A5A5);
        sample();
        pop_rd1();
        chk("r7_nobypass_old", nb_rdata1, 32'h0);
        begin_cyc();
        raddr1 = 5'd7;
        sample();
        chk("r7_nobypass_new", nb_rdata1, 32'hA5A5_A5A5);

        // Both ports hit r3: port 1 wins in storage and in forwarding.
        begin_cyc();
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h0000_0011;
        we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h0000_0022;
        raddr2 = 5'd3;
        sample();
        chk("r3_bypass_prio", rdata2, 32'h0000_0022);
        begin_cyc();
        raddr1 = 5'd3;
        raddr2 = 5'd0;
        push_rd("r3_stored", 32'h0000_0022);
        sample();
        pop_rd1();
        chk("r3_stored_nb", nb_rdata1, 32'h0000_0022);

        do_reset();

        // Reserve / busy / release sequence on r9.
        begin_cyc();
        rsv = 1'b1; rsv_addr = 5'd9;
        sample();
        chk("r9_rsv_ok", 32'(rsv_ok), 32'h1);
        begin_cyc();
        rsv = 1'b1; rsv_addr = 5'd9; raddr1 = 5'd9;
        sample();
        chk("r9_busy", 32'(rbusy1), 32'h1);
        chk("r9_rsv_again", 32'(rsv_ok), 32'h0);
        begin_cyc();
        we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h0000_0055; raddr1 = 5'd9;
        push_rd("r9_load_bypass", 32'h0000_0055);
        sample();
        pop_rd1();
        chk("r9_busy_fwd_clear", 32'(rbusy1), 32'h0);
        chk("r9_busy_nb_held", 32'(nb_rbusy1), 32'h1);
        begin_cyc();
        raddr1 = 5'd9;
        push_rd("r9_load_stored", 32'h0000_0055);
        sample();
        pop_rd1();
        chk("r9_busy_cleared", 32'(rbusy1), 32'h0);
        chk("r9_no_err", 32'(err), 32'h0);
        begin_cyc();
        rsv = 1'b1; rsv_addr = 5'd9;
        begin_cyc();
        rsv = 1'b1; rsv_addr = 5'd9;
        we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h0000_0066;
        sample();
        chk("r9_rsv_with_clear", 32'(rsv_ok), 32'h1);
        begin_cyc();
        raddr1 = 5'd9;
        rsv = 1'b1; rsv_addr = 5'd0;
        sample();
        chk("r9_busy_after_both", 32'(rbusy1), 32'h1);
        chk("r0_rsv_ok", 32'(rsv_ok), 32'h1);
        chk("r9_err_clean", 32'(err), 32'h0);
        begin_cyc();
        raddr2 = 5'd0;
        sample();
        chk("r0_never_busy", 32'(rbusy2), 32'h0);

        // WAW hazard on reserved r4.
        begin_cyc();
        rsv = 1'b1; rsv_addr = 5'd4;
        begin_cyc();
        we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h0000_0077;
        sample();
        chk("waw_err_pre", 32'(err), 32'h0);
        begin_cyc();
        raddr1 = 5'd4;
        push_rd("waw_data_stored", 32'h0000_0077);
        sample();
        pop_rd1();
        chk("waw_err_set", 32'(err), 32'h1);
        begin_cyc();
        begin_cyc();
        sample();
        chk("waw_err_sticky", 32'(err), 32'h1);

        // Stray load writeback to non-busy r6 after a fresh reset.
        do_reset();
        chk("rst_err_cleared", 32'(err), 32'h0);
        begin_cyc();
        we1 = 1'b1; waddr1 = 5'd6; wdata1 = 32'h0000_0042;
        begin_cyc();
        raddr1 = 5'd6;
        push_rd("stray_data_stored", 32'h0000_0042);
        sample();
        pop_rd1();
        chk("stray_err_set", 32'(err), 32'h1);

        // Asynchronous reset mid-load clears everything without a clock edge.
        do_reset();
        begin_cyc();
        rsv = 1'b1; rsv_addr = 5'd10;
        begin_cyc();
        we0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'h0000_BEEF;
        begin_cyc();
        raddr1 = 5'd10;
        sample();
        chk("async_pre_busy", 32'(rbusy1), 32'h1);
        chk("async_pre_err", 32'(err), 32'h1);
        chk("async_pre_data", rdata1, 32'h0000_BEEF);
        #1 reset_n = 1'b0;
        #1;
        chk("async_busy", 32'(rbusy1), 32'h0);
        chk("async_err", 32'(err), 32'h0);
        chk("async_rdata", rdata1, 32'h0);
        reset_n = 1'b1;
        #1;
        chk("async_reg_cleared", rdata1, 32'h0);
        chk("async_busy_released", 32'(rbusy1), 32'h0);
        chk("async_err_released", 32'(err), 32'h0);

        if (rd_q.size() != 0) begin
            n_vec++;
            n_err++;
            $error("FAIL rd_queue_drain observed=%0d expected=0", rd_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
